// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack data port with byte lanes, formatted load data; optional MEM_TIMEOUT_EN wait timeout.
// Latency: >=2 cycles in MEM, load data registered at the ack edge; backpressure: stall_mem held until dack (or timeout).
module mem_access_unit #(
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read_mem,
  input  logic                 mem_write_mem,
  input  logic [2:0]           funct3_mem,
  input  logic [DATA_SIZE-1:0] address_alu_result_mem,
  input  logic [DATA_SIZE-1:0] store_data_mem,
  output logic [DATA_SIZE-1:0] daddr,
  output logic [DATA_SIZE-1:0] ddata_w,
  output logic [3:0]           dbe,
  output logic                 dreq,
  output logic                 dwe,
  input  logic                 dack,
  input  logic [DATA_SIZE-1:0] ddata_r,
  output logic [DATA_SIZE-1:0] ddata_r_mem,
  output logic                 stall_mem,
  output logic                 access_err,
  output logic                 bus_err
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] daddr_q, daddr_d;
  logic [DATA_SIZE-1:0] ddata_w_q, ddata_w_d;
  logic [DATA_SIZE-1:0] ddata_r_mem_q, ddata_r_mem_d;
  logic [3:0]           dbe_q, dbe_d;
  logic                 dreq_q, dreq_d;
  logic                 dwe_q, dwe_d;
  logic                 access_err_q, access_err_d;
  logic [1:0]           off_q, off_d;
  logic [2:0]           f3_q, f3_d;
  logic                 stall_raw;

  logic [1:0]           addr_off;
  logic                 is_rd, is_wr, width_ok, align_ok, legal;
  logic [DATA_SIZE-1:0] st_data;
  logic [3:0]           st_be;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [DATA_SIZE-1:0] ld_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             timeout_hit;
  // The cycle in which the count would reach the limit is the last WAIT cycle.
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    addr_off = address_alu_result_mem[1:0];
    is_rd    = mem_read_mem & ~mem_write_mem;
    is_wr    = mem_write_mem & ~mem_read_mem;
    case (funct3_mem)
      3'b000, 3'b001, 3'b010: width_ok = is_rd | is_wr;
      3'b100, 3'b101:         width_ok = is_rd;
      default:                width_ok = 1'b0;
    endcase
    case (funct3_mem[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~addr_off[0];
      default: align_ok = (addr_off == 2'b00);
    endcase
    legal = width_ok & align_ok;
    case (funct3_mem[1:0])
      2'b00: begin
        st_data = {4{store_data_mem[7:0]}};
        st_be   = 4'b0001 << addr_off;
      end
      2'b01: begin
        st_data = {2{store_data_mem[15:0]}};
        st_be   = addr_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = store_data_mem;
        st_be   = 4'b1111;
      end
    endcase
  end

  // Load formatting works off the offset and width captured with the request.
  always_comb begin
    ld_byte = ddata_r[8*off_q +: 8];
    ld_half = ddata_r[16*off_q[1] +: 16];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = ddata_r;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    daddr_d       = daddr_q;
    ddata_w_d     = ddata_w_q;
    ddata_r_mem_d = ddata_r_mem_q;
    dbe_d         = dbe_q;
    dreq_d        = dreq_q;
    dwe_d         = dwe_q;
    off_d         = off_q;
    f3_d          = f3_q;
    access_err_d  = 1'b0;
    stall_raw     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    bus_err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (legal) begin
          stall_raw = 1'b1;
          state_d   = ST_WAIT;
          daddr_d   = {address_alu_result_mem[DATA_SIZE-1:2], 2'b00};
          ddata_w_d = st_data;
          dbe_d     = is_wr ? st_be : 4'b0000;
          dwe_d     = is_wr;
          dreq_d    = 1'b1;
          off_d     = addr_off;
          f3_d      = funct3_mem;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else if (mem_read_mem | mem_write_mem) begin
          access_err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dack) begin
          if (!dwe_q) ddata_r_mem_d = ld_data;
          dreq_d  = 1'b0;
          dwe_d   = 1'b0;
          dbe_d   = 4'b0000;
          state_d = ST_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout_hit) begin
          dreq_d    = 1'b0;
          dwe_d     = 1'b0;
          dbe_d     = 4'b0000;
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          stall_raw  = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`else
        else begin
          stall_raw = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      daddr_q       <= '0;
      ddata_w_q     <= '0;
      ddata_r_mem_q <= '0;
      dbe_q         <= 4'b0000;
      dreq_q        <= 1'b0;
      dwe_q         <= 1'b0;
      access_err_q  <= 1'b0;
      off_q         <= 2'b00;
      f3_q          <= 3'b000;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q    <= '0;
      bus_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      daddr_q       <= daddr_d;
      ddata_w_q     <= ddata_w_d;
      ddata_r_mem_q <= ddata_r_mem_d;
      dbe_q         <= dbe_d;
      dreq_q        <= dreq_d;
      dwe_q         <= dwe_d;
      access_err_q  <= access_err_d;
      off_q         <= off_d;
      f3_q          <= f3_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      bus_err_q     <= bus_err_d;
`endif
    end
  end

  assign daddr       = daddr_q;
  assign ddata_w     = ddata_w_q;
  assign dbe         = dbe_q;
  assign dreq        = dreq_q;
  assign dwe         = dwe_q;
  assign ddata_r_mem = ddata_r_mem_q;
  assign access_err  = access_err_q;
  assign stall_mem   = stall_raw & ~rst;

`ifdef MEM_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign bus_err        = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the ALU-computed address, store data and funct3, and drives a req/ack data-memory port with byte lanes.
- Stalls the pipeline until the memory acknowledges.
- Returns sign/zero-extended load data as a registered value; MEM/WB passes it straight to writeback.

Parameters:
- DATA_SIZE, 32: data and address width. Lane logic is fixed at 4 bytes, so only 32 is supported.
- TIMEOUT_CYCLES, 255: maximum cycles to wait for dack. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mem_read_mem  in  1  load in MEM stage.
- mem_write_mem  in  1  store in MEM stage.
- funct3_mem  in  3  RV32I load/store width code.
- address_alu_result_mem  in  DATA_SIZE  effective byte address.
- store_data_mem  in  DATA_SIZE  rs2 value for stores.
- daddr  out  DATA_SIZE  word-aligned memory address, registered.
- ddata_w  out  DATA_SIZE  lane-replicated store data, registered.
- dbe  out  4  byte enables, registered.
- dreq  out  1  request valid, registered.
- dwe  out  1  write enable, registered.
- dack  in  1  memory completion, one-cycle pulse.
- ddata_r  in  DATA_SIZE  raw memory read word, valid with dack.
- ddata_r_mem  out  DATA_SIZE  formatted load data, registered.
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB.
- access_err  out  1  one-cycle pulse for a misaligned or illegal access.
- bus_err  out  1  one-cycle timeout pulse. Driven only with MEM_TIMEOUT_EN; tied 0 otherwise.

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset, rst.
- Reset values: state IDLE; dreq, dwe, access_err, bus_err = 0; dbe = 0; daddr, ddata_w, ddata_r_mem = 0.
- stall_mem: combinational; 0 while rst is high.
- States:
  - IDLE: stall_mem = 1 iff (mem_read_mem XOR mem_write_mem) and the access is legal. On that condition, at the next edge: go to WAIT; load daddr = {addr[31:2], 2'b00}, dbe, ddata_w, dwe = mem_write_mem; dreq = 1.
  - WAIT: dreq stays 1 and all request outputs are held. stall_mem = !dack.
  - WAIT with dack = 1:
    - Load: ddata_r_mem <= formatted ddata_r.
    - Store: ddata_r_mem holds its value.
    - At the same edge: dreq <= 0, dwe <= 0, dbe <= 0; return to IDLE.
    - The pipeline advances at this edge, so WB sees the load data one cycle later.
    - Minimum MEM occupancy is 2 cycles.
- Upstream holds all *_mem inputs stable while stall_mem = 1. Inputs are sampled only in IDLE.
- Legality:
  - Loads: funct3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: funct3 in {000 SB, 001 SH, 010 SW}.
  - Halfword requires addr[0] = 0; word requires addr[1:0] = 0.
  - mem_read_mem and mem_write_mem both high is illegal.
- Illegal access in IDLE: no request; access_err = 1 for exactly one cycle (registered at the next edge); stall_mem = 0; ddata_r_mem holds.
- Store lanes:
  - SB: ddata_w = {4{data[7:0]}}, dbe = 1 << addr[1:0].
  - SH: ddata_w = {2{data[15:0]}}, dbe = addr[1] ? 1100 : 0011.
  - SW: data unchanged, dbe = 1111.
- Load format:
  - Byte select is ddata_r[8*addr[1:0] +: 8]; halfword select is ddata_r[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - Uses the address and funct3 held from the request.
- No access (both enables low): IDLE, outputs hold, stall_mem = 0.
- dack seen in IDLE: ignored.
- rst in WAIT: dreq drops at that edge, state goes to IDLE, no data is captured. A late dack is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - An 8+-bit wait counter clears on entry to WAIT and increments each WAIT cycle without dack.
  - When the count reaches TIMEOUT_CYCLES: dreq <= 0, return to IDLE, bus_err pulses 1 cycle, ddata_r_mem holds, stall_mem = 0 in that cycle.
  - dack and timeout in the same cycle: dack wins; no bus_err.
- When undefined: no counter logic; bus_err tied 0; WAIT lasts indefinitely until dack.

Test Plan:
- LB at addr 0x103, dack after 1 cycle with ddata_r = 0x80AA_BBCC -> daddr = 0x100, dbe = 0000 (read), stall_mem high 1 cycle plus the ack-cycle release, ddata_r_mem = 0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- SH at addr 0x202, data 0x1234_5678 -> daddr = 0x200, dbe = 1100, ddata_w = 0x5678_5678, dwe = 1, ddata_r_mem unchanged.
- LW at addr 0x006 (misaligned) -> dreq never asserts, access_err pulses 1 cycle, stall_mem = 0. SW with funct3 = 011 -> same.
- LW at 0x40 with dack delayed 5 cycles, ddata_r = 0xDEAD_BEEF -> stall_mem high for exactly 6 cycles, dreq high 5 cycles (+ack cycle), ddata_r_mem = 0xDEAD_BEEF one cycle after dack.
- rst asserted on the 2nd WAIT cycle, dack arriving the next cycle -> dreq = 0 after the reset edge, ddata_r_mem = 0, stall_mem = 0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no dack -> bus_err pulses after 4 WAIT cycles, dreq drops, state IDLE. Second run with dack on the 4th cycle -> no bus_err.
